// File: rtl/sar_compare_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sar_compare_ctrl_pkg
// Purpose : Shared constants for the SAR compare controller, the ADC block
//           that hosts it, and its bench. Holds the FSM state encoding and
//           the default code width and settle time.
// Ports   : none (package)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package sar_compare_ctrl_pkg;

    // Default code width and extra settle cycles per trial.
    localparam int SAR_WIDTH         = 7;
    localparam int SAR_SETTLE_CYCLES = 1;

    // FSM state encoding, kept as plain constants so legacy blocks can decode it.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRIAL  = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/sar_compare_ctrl_if.sv
// -----------------------------------------------------------------------------
// sar_compare_ctrl_if
// Purpose : Bundles the conversion request, comparator feedback and result
//           signals of the SAR compare controller.
// Signals : start          - conversion request (master -> slave)
//           cmp_gt, cmp_eq - comparator decision (master -> slave)
//           analogcompare  - trial code to the comparator (slave -> master)
//           dout           - last converted code
//           valid          - one-cycle completion pulse
//           busy           - conversion in progress
//           trustbit       - verify trial confirmed analog >= dout
// Modports: master - requester / comparator side
//           slave  - the controller
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface sar_compare_ctrl_if #(
    parameter int WIDTH = 7
) ();
    logic             start;
    logic             cmp_gt;
    logic             cmp_eq;
    logic [WIDTH-1:0] analogcompare;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;
    logic             trustbit;

    modport master (
        output start, cmp_gt, cmp_eq,
        input  analogcompare, dout, valid, busy, trustbit
    );

    modport slave (
        input  start, cmp_gt, cmp_eq,
        output analogcompare, dout, valid, busy, trustbit
    );
endinterface

// File: rtl/sar_compare_ctrl_settle_cnt.sv
// -----------------------------------------------------------------------------
// sar_compare_ctrl_settle_cnt
// Purpose : Loadable down-counter that times how long each trial code is held
//           before the comparator is sampled. Reloaded at every trial boundary.
// Ports   : clk  - system clock
//           rst  - asynchronous active-high reset
//           load - reload the counter with SETTLE_CYCLES
//           done - counter has reached zero (last cycle of the trial)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sar_compare_ctrl_settle_cnt #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            // Saturates at zero so an idle counter never wraps.
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sar_compare_ctrl.sv
// -----------------------------------------------------------------------------
// sar_compare_ctrl
// Purpose : Successive-approximation controller. Drives a trial code to the
//           comparator, binary-searches MSB to LSB, then repeats the final
//           code once as a verify trial. The result is published on dout with
//           a one-cycle valid pulse and a trustbit from the verify trial.
// Ports   : clk - system clock, rising edge
//           rst - asynchronous active-high reset
//           bus - sar_compare_ctrl_if.slave (start, cmp_gt, cmp_eq in;
//                 analogcompare, dout, valid, busy, trustbit out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sar_compare_ctrl
    import sar_compare_ctrl_pkg::*;
#(
    parameter int WIDTH         = SAR_WIDTH,
    parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    sar_compare_ctrl_if.slave    bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] code;
    logic [WIDTH-1:0] dout_r;
    logic             valid_r;
    logic             busy_r;
    logic             trust_r;

    logic             ge;
    logic             accept;
    logic             settle_load;
    logic             settle_done;
    logic [WIDTH-1:0] bit_cur;
    logic [WIDTH-1:0] bit_next;
    logic [WIDTH-1:0] acc_new;

    // Comparator says analog >= trial code.
    assign ge          = bus.cmp_gt | bus.cmp_eq;
    assign accept      = (state == ST_IDLE) && bus.start;
    // Reload on conversion start and at every trial boundary (incl. entry to VERIFY).
    assign settle_load = accept || ((state == ST_TRIAL) && settle_done);

    sar_compare_ctrl_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (settle_load),
        .done (settle_done)
    );

    // Bit under test, the next lower bit, and the accumulator after this decision.
    always_comb begin
        bit_cur  = WIDTH'(1) << idx;
        bit_next = (idx != '0) ? (bit_cur >> 1) : '0;
        acc_new  = ge ? (acc | bit_cur) : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            acc     <= '0;
            code    <= '0;
            dout_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            trust_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_TRIAL;
                        idx    <= IDX_W'(WIDTH - 1);
                        acc    <= '0;
                        code   <= MSB_CODE;
                        busy_r <= 1'b1;
                    end
                end
                ST_TRIAL: begin
                    if (settle_done) begin
                        acc <= acc_new;
                        if (idx != '0) begin
                            idx  <= idx - 1'b1;
                            code <= acc_new | bit_next;
                        end else begin
                            // Final code is re-presented unchanged for the verify trial.
                            code  <= acc_new;
                            state <= ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (settle_done) begin
                        trust_r <= ge;
                        dout_r  <= acc;
                        valid_r <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.analogcompare = code;
    assign bus.dout          = dout_r;
    assign bus.valid         = valid_r;
    assign bus.busy          = busy_r;
    assign bus.trustbit      = trust_r;

endmodule
